spi_slave_fd: RTL

SPI_SLAVE_FD -- requirements
Module: spi_slave_fd

---
 rtl/spi_fd_pkg.sv | 8 +
 rtl/spi_fd_sync.sv | 17 +
 rtl/spi_slave_fd.sv | 113 +++++++++++
 3 files changed

// File: rtl/spi_fd_pkg.sv
// spi_fd_pkg: shared state encoding and SPI mode constants for spi_slave_fd
package spi_fd_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam int CPOL_LOW = 0;
  localparam int CPOL_HIGH = 1;
  localparam int CPHA_LEAD = 0;
  localparam int CPHA_TRAIL = 1;
endpackage

// File: rtl/spi_fd_sync.sv
// spi_sync: 2-flop synchronizer for one asynchronous SPI pin, reset to RST_VAL
module spi_sync
  import spi_fd_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  // two-stage capture of the pin into the clk domain
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= {2{RST_VAL}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/spi_slave_fd.sv
// spi_slave_fd: full-duplex SPI slave with rx/tx streams; define SPI_FD_OVERRUN_EN for a sticky rx_overrun flag
module spi_slave_fd
  import spi_fd_pkg::*;
#(
  parameter int N = 8,
  parameter int CPOL = CPOL_LOW,
  parameter int CPHA = CPHA_LEAD,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sck,
  input  logic         mosi,
  input  logic         cs_n,
  output logic         miso,
  output logic         miso_oe,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         busy,
  output logic         rx_overrun
);
  localparam int CW = $clog2(N);
  state_t state;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0] rx_sr, tx_sr, tx_buf, rx_next, tx_word;
  logic sck_s, sck_d, mosi_s, cs_s, miso_r, tx_full;
  logic rise, fall, lead, trail, smp, shf, active, done, load, tx_wr;
  spi_sync #(.RST_VAL(1'(CPOL))) u_sck (.clk(clk), .reset(reset), .d(sck), .q(sck_s));
  spi_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));
  spi_sync #(.RST_VAL(1'b1)) u_cs (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  // one extra delay on synchronized sck for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) sck_d <= 1'(CPOL);
    else sck_d <= sck_s;
  assign rise = sck_s & ~sck_d;
  assign fall = ~sck_s & sck_d;
  assign lead = (CPOL == CPOL_HIGH) ? fall : rise;
  assign trail = (CPOL == CPOL_HIGH) ? rise : fall;
  assign smp = (CPHA == CPHA_TRAIL) ? trail : lead;
  assign shf = (CPHA == CPHA_TRAIL) ? lead : trail;
  assign active = (state == XFER) & ~cs_s;
  assign done = active & smp & (bit_cnt == '0);
  assign load = ((state == IDLE) & ~cs_s) | done;
  assign rx_next = (LSB_FIRST != 0) ? {mosi_s, rx_sr[N-1:1]} : {rx_sr[N-2:0], mosi_s};
  assign tx_word = tx_full ? tx_buf : '0;
  assign tx_wr = tx_valid & ~tx_full;
  assign tx_ready = ~tx_full;
  assign busy = (state == XFER);
  assign miso_oe = ~cs_s;
  assign miso = miso_r & miso_oe;
  // bit of the held TX word that goes out while bit_cnt has value c
  function automatic logic pick(input logic [N-1:0] w, input logic [CW-1:0] c);
    return (LSB_FIRST != 0) ? w[(N-1) - int'(c)] : w[c];
  endfunction
  // transfer FSM: miso is re-driven from bit_cnt on every shift edge, so the
  // shift edge right after a reload just repeats the already-presented first bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= CW'(N-1);
      rx_sr <= '0;
      tx_sr <= '0;
      miso_r <= 1'b0;
    end else if (cs_s) begin
      state <= IDLE;
      bit_cnt <= CW'(N-1);
      miso_r <= 1'b0;
    end else if (load) begin
      state <= XFER;
      bit_cnt <= CW'(N-1);
      tx_sr <= tx_word;
      miso_r <= pick(tx_word, CW'(N-1));
    end else if (active) begin
      if (smp) begin
        rx_sr <= rx_next;
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (shf) miso_r <= pick(tx_sr, bit_cnt);
    end
  // receive stream: a completed word is dropped while an unaccepted one is held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
    end else if (done && (!rx_valid || rx_ready)) begin
      rx_valid <= 1'b1;
      rx_data <= rx_next;
    end else if (rx_ready) rx_valid <= 1'b0;
  // single-entry tx buffer, emptied by every shift-register load
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_full <= 1'b0;
      tx_buf <= '0;
    end else begin
      tx_full <= tx_wr | (tx_full & ~load);
      if (tx_wr) tx_buf <= tx_data;
    end
`ifdef SPI_FD_OVERRUN_EN
  logic ovr;
  // sticky overrun, cleared by the next accepted word
  always_ff @(posedge clk or posedge reset)
    if (reset) ovr <= 1'b0;
    else if (rx_valid && rx_ready) ovr <= 1'b0;
    else if (done && rx_valid) ovr <= 1'b1;
  assign rx_overrun = ovr;
`else
  assign rx_overrun = 1'b0;
`endif
endmodule
